// File: rtl/matmul_seq_nxn.sv
// Sequential NxN signed matrix multiplier: streams in A then B, computes C = A*B
// with a single shared multiply-accumulate, then streams C out row-major.
module matmul_seq_nxn #(
  parameter int N           = 2,
  parameter int W           = 2,
  parameter int RANGE_CHECK = 1,
  localparam int AW         = 2*W + $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ena,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_data,
  output logic          out_last,
  output logic          out_err,
  output logic          busy
);

  localparam int NN = N*N;
  localparam int XW = $clog2(NN);
  localparam int BW = $clog2(2*NN);
  localparam int IW = $clog2(N);

  localparam logic [1:0]    S_LOAD    = 2'd0;
  localparam logic [1:0]    S_COMP    = 2'd1;
  localparam logic [1:0]    S_OUT     = 2'd2;
  localparam logic [W-1:0]  MIN_VAL   = {1'b1, {(W-1){1'b0}}};
  localparam logic [XW-1:0] LAST_IDX  = XW'(NN-1);
  localparam logic [BW-1:0] A_BEATS   = BW'(NN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(2*NN-1);
  localparam logic [IW-1:0] LAST_IJK  = IW'(N-1);

  logic [W-1:0]  a_q [NN];
  logic [W-1:0]  b_q [NN];
  logic [AW-1:0] c_q [NN];

  logic [1:0]           state_q, state_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic [IW-1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
  logic [XW-1:0]        idx_q, idx_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 err_q, err_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [AW-1:0]        out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic                 out_err_q, out_err_d;
  logic                 busy_q, busy_d;

  logic                 go_s, in_fire_s, out_fire_s, err_nxt_s;
  logic                 a_we_s, b_we_s, c_we_s;
  logic [XW-1:0]        ld_addr_s, ma_addr_s, mb_addr_s, c_addr_s, nxt_idx_s;
  logic [W-1:0]         a_rd_s, b_rd_s;
  logic signed [AW-1:0] a_ext_s, b_ext_s, prod_s, mac_sum_s;

  // Handshakes never complete while disabled or held in reset.
  assign go_s      = ena & ~reset;
  assign in_ready  = in_ready_q & go_s;
  assign out_valid = out_valid_q & go_s;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_err   = out_err_q;
  assign busy      = busy_q;

  always_comb begin
    in_fire_s  = in_valid & in_ready_q & go_s & (state_q == S_LOAD);
    out_fire_s = out_valid_q & out_ready & go_s & (state_q == S_OUT);
    err_nxt_s  = err_q | ((RANGE_CHECK != 0) && (in_data == MIN_VAL));
    ld_addr_s  = (beat_q < A_BEATS) ? XW'(beat_q) : XW'(beat_q - A_BEATS);
    ma_addr_s  = XW'(i_q) * XW'(N) + XW'(k_q);
    mb_addr_s  = XW'(k_q) * XW'(N) + XW'(j_q);
    c_addr_s   = XW'(i_q) * XW'(N) + XW'(j_q);
    nxt_idx_s  = idx_q + XW'(1);
    a_rd_s     = a_q[ma_addr_s];
    b_rd_s     = b_q[mb_addr_s];
    a_ext_s    = {{(AW-W){a_rd_s[W-1]}}, a_rd_s};
    b_ext_s    = {{(AW-W){b_rd_s[W-1]}}, b_rd_s};
    prod_s     = a_ext_s * b_ext_s;
    mac_sum_s  = ((k_q == {IW{1'b0}}) ? {AW{1'b0}} : acc_q) + prod_s;
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_err_d   = out_err_q;
    busy_d      = busy_q;
    a_we_s      = 1'b0;
    b_we_s      = 1'b0;
    c_we_s      = 1'b0;
    if (go_s) begin
      case (state_q)
        S_LOAD: begin
          if (in_fire_s) begin
            a_we_s = (beat_q < A_BEATS);
            b_we_s = ~(beat_q < A_BEATS);
            err_d  = err_nxt_s;
            if (beat_q == LAST_BEAT) begin
              beat_d     = {BW{1'b0}};
              in_ready_d = 1'b0;
              busy_d     = 1'b1;
              // A flagged job has nothing worth computing: present zeros at once.
              if (err_nxt_s) begin
                state_d     = S_OUT;
                out_valid_d = 1'b1;
                out_data_d  = {AW{1'b0}};
                out_last_d  = 1'b0;
                out_err_d   = 1'b1;
              end else begin
                state_d = S_COMP;
              end
            end else begin
              beat_d = beat_q + BW'(1);
            end
          end else begin
            beat_d = beat_q;
          end
        end
        S_COMP: begin
          acc_d = mac_sum_s;
          if (k_q == LAST_IJK) begin
            c_we_s = 1'b1;
            k_d    = {IW{1'b0}};
            if (j_q == LAST_IJK) begin
              j_d = {IW{1'b0}};
              if (i_q == LAST_IJK) begin
                i_d         = {IW{1'b0}};
                state_d     = S_OUT;
                out_valid_d = 1'b1;
                out_data_d  = c_q[0];
                out_last_d  = 1'b0;
                out_err_d   = 1'b0;
              end else begin
                i_d = i_q + IW'(1);
              end
            end else begin
              j_d = j_q + IW'(1);
            end
          end else begin
            k_d = k_q + IW'(1);
          end
        end
        S_OUT: begin
          if (out_fire_s) begin
            if (idx_q == LAST_IDX) begin
              idx_d       = {XW{1'b0}};
              state_d     = S_LOAD;
              err_d       = 1'b0;
              in_ready_d  = 1'b1;
              out_valid_d = 1'b0;
              out_data_d  = {AW{1'b0}};
              out_last_d  = 1'b0;
              out_err_d   = 1'b0;
              busy_d      = 1'b0;
            end else begin
              idx_d      = nxt_idx_s;
              out_data_d = err_q ? {AW{1'b0}} : c_q[nxt_idx_s];
              out_last_d = (nxt_idx_s == LAST_IDX);
            end
          end else begin
            idx_d = idx_q;
          end
        end
        default: begin
          state_d = S_LOAD;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      beat_q      <= {BW{1'b0}};
      i_q         <= {IW{1'b0}};
      j_q         <= {IW{1'b0}};
      k_q         <= {IW{1'b0}};
      idx_q       <= {XW{1'b0}};
      acc_q       <= {AW{1'b0}};
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= {AW{1'b0}};
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_err_q   <= out_err_d;
      busy_q      <= busy_d;
    end
  end

  // Matrix storage has no reset; every job rewrites all of it before use.
  always_ff @(posedge clk) begin
    if (a_we_s) a_q[ld_addr_s] <= in_data;
    if (b_we_s) b_q[ld_addr_s] <= in_data;
    if (c_we_s) c_q[c_addr_s] <= mac_sum_s;
  end

endmodule

// File: tb/tb_matmul_seq_nxn.sv
// Self-checking bench for matmul_seq_nxn: a 2x2/W=2/range-checked instance and
// a 3x3/W=4/full-range instance, driven from vector tables and random jobs.
module tb_matmul_seq_nxn;

  typedef logic [8:0][7:0]  mat_t;
  typedef logic [8:0][15:0] res_t;
  typedef struct packed {
    logic [1:0] sel;
    mat_t       a;
    mat_t       b;
    res_t       c;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       ena_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a, out_err_a, busy_a;
  logic [1:0] in_data_a;
  logic [4:0] out_data_a;
  logic       ena_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b, out_err_b, busy_b;
  logic [3:0] in_data_b;
  logic [9:0] out_data_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ja[9];
  int   jb[9];
  int   exp_c[9];
  bit   exp_err;
  vec_t vecs[4];

  matmul_seq_nxn #(.N(2), .W(2), .RANGE_CHECK(1)) u_a (
    .clk(clk), .reset(reset), .ena(ena_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_last(out_last_a), .out_err(out_err_a), .busy(busy_a));

  matmul_seq_nxn #(.N(3), .W(4), .RANGE_CHECK(0)) u_b (
    .clk(clk), .reset(reset), .ena(ena_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_last(out_last_b), .out_err(out_err_b), .busy(busy_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int g_ir(int sel);   return (sel == 0) ? int'(in_ready_a)  : int'(in_ready_b);  endfunction
  function automatic int g_ov(int sel);   return (sel == 0) ? int'(out_valid_a) : int'(out_valid_b); endfunction
  function automatic int g_ol(int sel);   return (sel == 0) ? int'(out_last_a)  : int'(out_last_b);  endfunction
  function automatic int g_oe(int sel);   return (sel == 0) ? int'(out_err_a)   : int'(out_err_b);   endfunction
  function automatic int g_busy(int sel); return (sel == 0) ? int'(busy_a)      : int'(busy_b);      endfunction
  function automatic int g_od(int sel);
    return (sel == 0) ? int'($signed(out_data_a)) : int'($signed(out_data_b));
  endfunction

  task automatic set_in(int sel, bit v, int d);
    if (sel == 0) begin in_valid_a = v; in_data_a = 2'(d); end
    else begin in_valid_b = v; in_data_b = 4'(d); end
  endtask
  task automatic set_ena(int sel, bit v);
    if (sel == 0) ena_a = v; else ena_b = v;
  endtask
  task automatic set_or(int sel, bit v);
    if (sel == 0) out_ready_a = v; else out_ready_b = v;
  endtask

  function automatic mat_t m2(int e0, int e1, int e2, int e3);
    mat_t m = '0;
    m[0] = 8'(e0); m[1] = 8'(e1); m[2] = 8'(e2); m[3] = 8'(e3);
    return m;
  endfunction
  function automatic mat_t mfill(int v);
    mat_t m = '0;
    for (int x = 0; x < 9; x++) m[x] = 8'(v);
    return m;
  endfunction
  function automatic res_t r2(int e0, int e1, int e2, int e3);
    res_t r = '0;
    r[0] = 16'(e0); r[1] = 16'(e1); r[2] = 16'(e2); r[3] = 16'(e3);
    return r;
  endfunction
  function automatic res_t rfill(int v);
    res_t r = '0;
    for (int x = 0; x < 9; x++) r[x] = 16'(v);
    return r;
  endfunction

  task automatic load_vec(int v);
    for (int x = 0; x < 9; x++) begin
      ja[x]    = int'($signed(vecs[v].a[x]));
      jb[x]    = int'($signed(vecs[v].b[x]));
      exp_c[x] = int'($signed(vecs[v].c[x]));
    end
    exp_err = vecs[v].err;
  endtask

  // Reference: plain matrix product, with the whole job zeroed if any element is out of range.
  task automatic model(int n, int w, bit rc);
    int s;
    exp_err = 1'b0;
    for (int x = 0; x < n*n; x++)
      if (rc && (ja[x] == -(1 << (w-1)) || jb[x] == -(1 << (w-1)))) exp_err = 1'b1;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += ja[i*n+k] * jb[k*n+j];
        exp_c[i*n+j] = exp_err ? 0 : s;
      end
  endtask

  task automatic send(int sel, int n, bit gaps, int freeze_at, output int t_last);
    int beat = 0, guard = 0, d;
    bit v, frozen = 1'b0;
    t_last = -1;
    while (beat < 2*n*n && guard < 1000) begin
      @(negedge clk);
      d = (beat < n*n) ? ja[beat] : jb[beat - n*n];
      v = !gaps || ($urandom_range(0, 3) != 0);
      set_in(sel, v, d);
      if (beat == freeze_at && !frozen) begin
        frozen = 1'b1;
        v = 1'b1;
        set_in(sel, 1'b1, d);
        set_ena(sel, 1'b0);
        for (int f = 0; f < 5; f++) begin
          #1;
          check("frz_load_in_ready", g_ir(sel), 0);
          @(negedge clk);
        end
        set_ena(sel, 1'b1);
      end
      #1;
      if (v && g_ir(sel) != 0) begin
        t_last = cyc;
        beat++;
      end
      guard++;
    end
    check("beats_in", beat, 2*n*n);
  endtask

  task automatic collect(int sel, int n, int mode, int freeze_at, int t_last, int exp_lat);
    int idx = 0, guard = 0, pat = 0, held_d = 0, held_l = 0, fd = 0, rdy = 0;
    bit first = 1'b1, stalled = 1'b0, frozen = 1'b0;
    while (idx < n*n && guard < 3000) begin
      @(negedge clk);
      set_in(sel, 1'b0, 0);
      case (mode)
        0:       rdy = 1;
        1:       rdy = (pat % 3 == 0) ? 1 : 0;
        default: rdy = int'($urandom_range(0, 1));
      endcase
      pat++;
      set_or(sel, rdy[0]);
      if (!first && !frozen && idx == freeze_at) begin
        frozen = 1'b1;
        fd = g_od(sel);
        set_ena(sel, 1'b0);
        for (int f = 0; f < 5; f++) begin
          #1;
          check("frz_out_valid", g_ov(sel), 0);
          check("frz_out_in_ready", g_ir(sel), 0);
          check("frz_out_data", g_od(sel), fd);
          @(negedge clk);
        end
        set_ena(sel, 1'b1);
      end
      #1;
      if (g_ov(sel) != 0) begin
        if (first) begin
          check("latency", cyc - t_last, exp_lat);
          first = 1'b0;
        end
        if (stalled) begin
          check("hold_data", g_od(sel), held_d);
          check("hold_last", g_ol(sel), held_l);
        end
        if (rdy != 0) begin
          check("out_data", g_od(sel), exp_c[idx]);
          check("out_last", g_ol(sel), (idx == n*n-1) ? 1 : 0);
          check("out_err", g_oe(sel), exp_err ? 1 : 0);
          check("in_ready_while_busy", g_ir(sel), 0);
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_d  = g_od(sel);
          held_l  = g_ol(sel);
        end
      end
      guard++;
    end
    check("beats_out", idx, n*n);
    @(negedge clk);
    set_or(sel, 1'b0);
    #1;
    check("post_in_ready", g_ir(sel), 1);
    check("post_out_valid", g_ov(sel), 0);
    check("post_busy", g_busy(sel), 0);
  endtask

  task automatic run_job(int sel, int mode, bit gaps, int fin, int fout);
    int n = (sel == 0) ? 2 : 3;
    int t_last;
    send(sel, n, gaps, fin, t_last);
    collect(sel, n, mode, fout, t_last, exp_err ? 1 : n*n*n + 1);
  endtask

  initial begin
    int t_last;
    vecs[0] = '{sel: 2'd0, a: m2(1, 1, 0, -1), b: m2(1, 0, 1, -2), c: r2(0, 0, 0, 0),  err: 1'b1};
    vecs[1] = '{sel: 2'd0, a: m2(1, 1, 0, -1), b: m2(1, 0, 1, 1),  c: r2(2, 1, -1, -1), err: 1'b0};
    vecs[2] = '{sel: 2'd1, a: mfill(-8), b: mfill(-8), c: rfill(192),  err: 1'b0};
    vecs[3] = '{sel: 2'd1, a: mfill(7),  b: mfill(-7), c: rfill(-147), err: 1'b0};

    reset = 1'b1;
    ena_a = 1'b1; in_valid_a = 1'b0; in_data_a = '0; out_ready_a = 1'b0;
    ena_b = 1'b1; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready_during", int'(in_ready_a), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", int'(in_ready_a), 1);
    check("rst_out_valid", int'(out_valid_a), 0);
    check("rst_out_data", g_od(0), 0);
    check("rst_out_last", int'(out_last_a), 0);
    check("rst_out_err", int'(out_err_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_b_out_data", g_od(1), 0);

    for (int v = 0; v < 4; v++) begin
      load_vec(v);
      run_job(int'(vecs[v].sel), 0, 1'b0, -1, -1);
    end

    // Backpressure with out_ready pattern 1,0,0,1,...
    load_vec(1);
    run_job(0, 1, 1'b0, -1, -1);

    // Reset three cycles into COMPUTE, then a fresh job.
    load_vec(1);
    send(0, 2, 1'b0, -1, t_last);
    @(negedge clk);
    set_in(0, 1'b0, 0);
    @(negedge clk);
    #1;
    check("mid_compute_busy", int'(busy_a), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", int'(in_ready_a), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("after_rst_out_valid", int'(out_valid_a), 0);
    check("after_rst_busy", int'(busy_a), 0);
    check("after_rst_in_ready", int'(in_ready_a), 1);
    run_job(0, 0, 1'b0, -1, -1);

    // Enable dropped mid-LOAD and mid-OUTPUT.
    load_vec(1);
    run_job(0, 0, 1'b0, 2, 1);

    for (int r = 0; r < 8; r++) begin
      int sel = r % 2;
      int n   = (sel == 0) ? 2 : 3;
      int w   = (sel == 0) ? 2 : 4;
      for (int x = 0; x < 9; x++) begin
        if (sel == 0 && (r % 4) == 0) begin
          ja[x] = int'($urandom_range(0, 2)) - 1;
          jb[x] = int'($urandom_range(0, 2)) - 1;
        end else begin
          ja[x] = int'($urandom_range(0, (1 << w) - 1)) - (1 << (w-1));
          jb[x] = int'($urandom_range(0, (1 << w) - 1)) - (1 << (w-1));
        end
      end
      model(n, w, sel == 0);
      run_job(sel, 2, 1'b1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
